// File: rtl/axi_ads124x_spi_arb_if.sv
// Signal bundle between the ADS124x requesters, the SPI byte engine and the
// transaction arbiter. The slave view is the arbiter; the master view is its environment.
interface axi_ads124x_spi_arb_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_data;
  logic [31:0] req1_data;
  logic [1:0]  req0_nbytes;
  logic [1:0]  req1_nbytes;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  spitx_axis_tdata;
  logic        spitx_axis_tvalid;
  logic        spitx_axis_tready;
  logic [7:0]  spirx_axis_tdata;
  logic        spirx_axis_tvalid;
  logic        spirx_axis_tready;
  logic        busy;
  logic        grant;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_nbytes, req1_nbytes,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output spitx_axis_tdata, spitx_axis_tvalid,
    input  spitx_axis_tready,
    input  spirx_axis_tdata, spirx_axis_tvalid,
    output spirx_axis_tready,
    output busy, grant
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_nbytes, req1_nbytes,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  spitx_axis_tdata, spitx_axis_tvalid,
    output spitx_axis_tready,
    output spirx_axis_tdata, spirx_axis_tvalid,
    input  spirx_axis_tready,
    input  busy, grant
  );
endinterface

// File: rtl/axi_ads124x_spi_arb.sv
// Shares one SPI byte engine between the auto-sampling sequencer (req0) and the
// O&M register path (req1), one 1-4 byte transaction at a time.
//
// state   | meaning
// IDLE    | no transaction; arbitrate and accept a request
// TX      | sending payload bytes MSB-first, RX bytes may already arrive
// WAIT_RX | all TX bytes sent, collecting the remaining RX bytes
// DONE    | one-cycle response strobe to the owner
module axi_ads124x_spi_arb #(
  parameter int C_TIMEOUT = 4096
) (
  input logic                  aclk,
  input logic                  areset,
  axi_ads124x_spi_arb_if.slave bus
);
  localparam int TW = $clog2(C_TIMEOUT);
  // Down-counter reload chosen so DONE lands C_TIMEOUT cycles after the last progress.
  localparam logic [TW-1:0] TMR_LOAD = TW'(C_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, TX, WAIT_RX, DONE} state_t;

  state_t        state, state_nxt;
  logic          last_grant, owner, winner, accept, active;
  logic          tx_hs, tx_last, rx_byte, rx_last, timeout;
  logic [31:0]   payload, shift, shift_nxt, rsp_data_q;
  logic [1:0]    nbytes_q, tx_idx, rx_cnt;
  logic [TW-1:0] tmr;
  logic          err_q;

  assign winner    = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign accept    = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign active    = (state == TX) || (state == WAIT_RX);
  assign tx_hs     = (state == TX) && bus.spitx_axis_tready;
  assign tx_last   = tx_hs && (tx_idx == 2'd0);
  assign rx_byte   = active && bus.spirx_axis_tvalid;
  assign rx_last   = rx_byte && (rx_cnt == nbytes_q);
  assign timeout   = active && !tx_hs && !rx_byte && (tmr == '0);
  assign shift_nxt = {shift[23:0], bus.spirx_axis_tdata};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = TX;
      TX: begin
        if (rx_last || timeout) state_nxt = DONE;
        else if (tx_last)       state_nxt = WAIT_RX;
      end
      WAIT_RX: if (rx_last || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready        = accept && !winner;
    bus.req1_ready        = accept && winner;
    bus.rsp0_valid        = (state == DONE) && !owner;
    bus.rsp1_valid        = (state == DONE) && owner;
    bus.spitx_axis_tvalid = (state == TX);
    bus.busy              = (state != IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      payload    <= '0;
      nbytes_q   <= '0;
      tx_idx     <= '0;
      rx_cnt     <= '0;
      shift      <= '0;
      tmr        <= TMR_LOAD;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= winner;
        owner      <= winner;
        payload    <= winner ? bus.req1_data : bus.req0_data;
        nbytes_q   <= winner ? bus.req1_nbytes : bus.req0_nbytes;
        tx_idx     <= winner ? bus.req1_nbytes : bus.req0_nbytes;
        rx_cnt     <= '0;
        shift      <= '0;
        tmr        <= TMR_LOAD;
      end else begin
        if (tx_hs && (tx_idx != 2'd0)) tx_idx <= tx_idx - 2'd1;
        if (rx_byte) begin
          shift  <= shift_nxt;
          rx_cnt <= rx_cnt + 2'd1;
        end
        if (tx_hs || rx_byte)          tmr <= TMR_LOAD;
        else if (active && tmr != '0)  tmr <= tmr - TW'(1);
      end
      // Response is captured separately so it survives the next acceptance.
      if (rx_last || timeout) begin
        rsp_data_q <= rx_last ? shift_nxt : shift;
        err_q      <= timeout;
      end
    end
  end

  assign bus.spitx_axis_tdata  = payload[{tx_idx, 3'b000} +: 8];
  assign bus.spirx_axis_tready = 1'b1;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_err           = err_q;
  assign bus.grant             = owner;
endmodule

// File: tb/tb_axi_ads124x_spi_arb.sv
// Directed, table-driven bench for the ADS124x SPI transaction arbiter with an
// echoing byte-engine model; reset-abort and idle-stray cases are hand-sequenced.
module tb_axi_ads124x_spi_arb;
  localparam int C_TO = 16;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_ads124x_spi_arb_if bus();

  axi_ads124x_spi_arb #(.C_TIMEOUT(C_TO)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.slave)
  );

  typedef struct {
    bit          tie;
    bit          sel;
    logic [31:0] data;
    logic [1:0]  nb;
    logic [31:0] rx;
    int          n_rx;
    int          stall_at;
    int          stall_len;
    bit          stray;
    logic [31:0] exp_rsp;
    bit          exp_err;
    int          exp_gap;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev_rsp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'(0));
    check({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'(0));
    check({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'(0));
    check({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'(0));
    check({tag, "_rsp_data"}, bus.rsp_data, 32'h0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(0));
    check({tag, "_tdata"}, 32'(bus.spitx_axis_tdata), 32'h0);
    check({tag, "_tvalid"}, 32'(bus.spitx_axis_tvalid), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_grant"}, 32'(bus.grant), 32'(0));
    check({tag, "_rx_tready"}, 32'(bus.spirx_axis_tready), 32'(1));
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          tx_n, rx_sent, pend, stall_left, last_prog, rsp_cyc;
    bit          other_seen;
    logic [31:0] d;
    string       tag;
    tag = $sformatf("v%0d", idx);

    if (v.stray) begin
      @(negedge aclk);
      bus.spirx_axis_tdata  = 8'h77;
      bus.spirx_axis_tvalid = 1'b1;
      #1;
      check({tag, "_stray_busy"}, 32'(bus.busy), 32'(0));
    end

    @(negedge aclk);
    bus.spirx_axis_tvalid = 1'b0;
    bus.spitx_axis_tready = 1'b1;
    if (v.tie || !v.sel) begin
      bus.req0_valid  = 1'b1;
      bus.req0_data   = v.data;
      bus.req0_nbytes = v.nb;
    end
    if (v.tie || v.sel) begin
      bus.req1_valid  = 1'b1;
      bus.req1_data   = v.data;
      bus.req1_nbytes = v.nb;
    end
    #1;
    check({tag, "_ready0"}, 32'(bus.req0_ready), 32'(!v.sel));
    check({tag, "_ready1"}, 32'(bus.req1_ready), 32'(v.sel));

    tx_n = 0; rx_sent = 0; pend = 0; stall_left = v.stall_len;
    last_prog = 0; rsp_cyc = -1; other_seen = 1'b0;
    for (int cyc = 1; cyc <= 80 && rsp_cyc < 0; cyc++) begin
      @(negedge aclk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (pend > 0 && rx_sent < v.n_rx) begin
        d = v.rx << (8 * rx_sent);
        bus.spirx_axis_tdata  = d[31:24];
        bus.spirx_axis_tvalid = 1'b1;
        rx_sent++;
        pend--;
      end else begin
        bus.spirx_axis_tvalid = 1'b0;
      end
      if (tx_n == v.stall_at && stall_left > 0) begin
        bus.spitx_axis_tready = 1'b0;
        stall_left--;
      end else begin
        bus.spitx_axis_tready = 1'b1;
      end
      #1;
      if (cyc == 1) begin
        check({tag, "_busy_c1"}, 32'(bus.busy), 32'(1));
        check({tag, "_grant_c1"}, 32'(bus.grant), 32'(v.sel));
        check({tag, "_rsp_hold_c1"}, bus.rsp_data, prev_rsp);
      end
      if (!bus.spitx_axis_tready && tx_n == v.stall_at) begin
        d = v.data << (8 * (3 - int'(v.nb) + tx_n));
        check({tag, "_stall_tvalid"}, 32'(bus.spitx_axis_tvalid), 32'(1));
        check({tag, "_stall_tdata"}, 32'(bus.spitx_axis_tdata), 32'(d[31:24]));
      end
      if (bus.spitx_axis_tvalid && bus.spitx_axis_tready) begin
        if (tx_n <= int'(v.nb)) begin
          d = v.data << (8 * (3 - int'(v.nb) + tx_n));
          check($sformatf("%s_tx_byte%0d", tag, tx_n), 32'(bus.spitx_axis_tdata), 32'(d[31:24]));
          if (v.stall_at < 0)
            check($sformatf("%s_tx_cyc%0d", tag, tx_n), cyc, tx_n + 1);
        end
        tx_n++;
        pend++;
        last_prog = cyc;
      end
      if (bus.spirx_axis_tvalid) last_prog = cyc;
      if (v.sel ? bus.rsp0_valid : bus.rsp1_valid) other_seen = 1'b1;
      if (v.sel ? bus.rsp1_valid : bus.rsp0_valid) begin
        rsp_cyc = cyc;
        check({tag, "_rsp_data"}, bus.rsp_data, v.exp_rsp);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
        check({tag, "_rsp_gap"}, cyc - last_prog, v.exp_gap);
        check({tag, "_grant_done"}, 32'(bus.grant), 32'(v.sel));
      end
    end
    check({tag, "_rsp_seen"}, 32'(rsp_cyc > 0), 32'(1));
    check({tag, "_tx_count"}, tx_n, int'(v.nb) + 1);
    check({tag, "_other_rsp"}, 32'(other_seen), 32'(0));

    @(negedge aclk);
    bus.spirx_axis_tvalid = 1'b0;
    bus.spitx_axis_tready = 1'b1;
    #1;
    check({tag, "_busy_after"}, 32'(bus.busy), 32'(0));
    check({tag, "_rsp_pulse_end"}, 32'(bus.rsp0_valid | bus.rsp1_valid), 32'(0));
    check({tag, "_rsp_held"}, bus.rsp_data, v.exp_rsp);
    prev_rsp = v.exp_rsp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            tie sel data          nb rx            nrx stall len stray exp_rsp       err gap
    vecs[0] = '{1'b1, 1'b0, 32'h0040_0017, 2'd2, 32'hAABB_CC00, 3, -1, 0, 1'b0, 32'h00AA_BBCC, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_A55A, 2'd1, 32'h1234_0000, 2, -1, 0, 1'b0, 32'h0000_1234, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_00DE, 2'd0, 32'h5C00_0000, 1, -1, 0, 1'b0, 32'h0000_005C, 1'b0, 1};
    vecs[3] = '{1'b0, 1'b1, 32'h1234_5678, 2'd3, 32'h0102_0304, 4,  2, 5, 1'b0, 32'h0102_0304, 1'b0, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_BEEF, 2'd1, 32'h5A00_0000, 1, -1, 0, 1'b0, 32'h0000_005A, 1'b1, C_TO};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_009F, 2'd0, 32'h0100_0000, 1, -1, 0, 1'b1, 32'h0000_0001, 1'b0, 1};
    vecs[6] = '{1'b0, 1'b0, 32'hCAFE_F00D, 2'd3, 32'h1122_3344, 4, -1, 0, 1'b0, 32'h1122_3344, 1'b0, 1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0055, 2'd0, 32'hE700_0000, 1, -1, 0, 1'b0, 32'h0000_00E7, 1'b0, 1};

    bus.req0_valid = 1'b0;  bus.req1_valid = 1'b0;
    bus.req0_data = '0;     bus.req1_data = '0;
    bus.req0_nbytes = '0;   bus.req1_nbytes = '0;
    bus.spitx_axis_tready = 1'b1;
    bus.spirx_axis_tdata = '0;
    bus.spirx_axis_tvalid = 1'b0;
    prev_rsp = 32'h0;

    @(negedge aclk);
    #1;
    check_reset_outputs("por");
    @(negedge aclk);
    areset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Abort a 4-byte req1 transaction in its second TX cycle.
    @(negedge aclk);
    bus.req1_valid  = 1'b1;
    bus.req1_data   = 32'hA1B2_C3D4;
    bus.req1_nbytes = 2'd3;
    #1;
    check("rst_ready1", 32'(bus.req1_ready), 32'(1));
    @(negedge aclk);
    bus.req1_valid = 1'b0;
    #1;
    check("rst_tvalid_c1", 32'(bus.spitx_axis_tvalid), 32'(1));
    check("rst_tdata_c1", 32'(bus.spitx_axis_tdata), 32'hA1);
    @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      check($sformatf("midrst_no_rsp%0d", i), 32'(bus.rsp0_valid | bus.rsp1_valid), 32'(0));
    end
    @(negedge aclk);
    areset = 1'b0;
    prev_rsp = 32'h0;

    run_txn(vecs[7], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
